// File: rtl/legv8_pc_branch_sequencer.sv
// LEGv8 PC / branch sequencer.
// Owns the fetch PC and resolves CBZ/B branches arriving from EX/MEM.
// A taken branch redirects the PC and then holds Flush for FLUSH_CYCLES
// unstalled cycles. While Flush is held, younger branches are squashed.
module legv8_pc_branch_sequencer #(
   parameter int                  PC_WIDTH     = 64,
   parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
   parameter int                  FLUSH_CYCLES = 3
) (
   input  logic                CLOCK,
   input  logic                RESET_N,
   input  logic                Stall,
   input  logic                ResolveValid,
   input  logic                Branch,
   input  logic                Zero,
   input  logic                UncondBranch,
   input  logic [PC_WIDTH-1:0] BranchPC,
   input  logic [PC_WIDTH-1:0] BranchOffset,
   output logic [PC_WIDTH-1:0] PC,
   output logic                PCSrc,
   output logic                Flush,
   output logic [15:0]         BranchCount
);

   localparam logic ST_RUN   = 1'b0;
   localparam logic ST_FLUSH = 1'b1;

   // The counter is loaded with (cycles - 1), and the flush exits once the counter reaches zero.
   localparam logic       HAS_FLUSH  = (FLUSH_CYCLES > 0);
   localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [15:0]         bcount_q, bcount_d;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] target;
   logic                taken;

   // Both adders wrap modulo 2^PC_WIDTH. The offset is a word offset, so it is scaled by 4.
   assign pc_inc = pc_q + PC_WIDTH'(4);
   assign target = BranchPC + (BranchOffset << 2);

   // ResolveValid gates the condition, so an undriven condition bit cannot leak through when it is idle.
   assign taken = ResolveValid & ((Branch & Zero) | UncondBranch) & (state_q == ST_RUN);

   assign PC          = pc_q;
   assign PCSrc       = taken;
   assign Flush       = (state_q == ST_FLUSH);
   assign BranchCount = bcount_q;

   // Next-state logic for the PC, the run/flush state, the flush counter and the branch counter.
   always_comb begin
      pc_d     = pc_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      bcount_d = bcount_q;
      case (state_q)
         ST_RUN: begin
            if (taken) begin
               // A redirect wins over a stall. A stalled fetch would otherwise lose the target.
               pc_d = target;
               if (bcount_q != 16'hFFFF) bcount_d = bcount_q + 16'd1;
               if (HAS_FLUSH) begin
                  state_d = ST_FLUSH;
                  cnt_d   = FLUSH_LOAD;
               end
            end else if (!Stall) begin
               pc_d = pc_inc;
            end
         end
         ST_FLUSH: begin
            // Only unstalled cycles count toward the flush length.
            if (!Stall) begin
               pc_d = pc_inc;
               if (cnt_q == 4'd0) state_d = ST_RUN;
               else               cnt_d   = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State registers. An asynchronous reset aborts any flush in progress.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         pc_q     <= RESET_PC;
         state_q  <= ST_RUN;
         cnt_q    <= 4'd0;
         bcount_q <= 16'd0;
      end else begin
         pc_q     <= pc_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bcount_q <= bcount_d;
      end
   end

endmodule
